// File: rtl/sprite_vram_loader_if.sv
// rtl/sprite_vram_loader_if.sv - pixel stream and VRAM write bus for the sprite loader
//   in_valid/in_data/in_last : pixel source -> loader
//   in_ready                 : loader -> pixel source
//   mem_addr/mem_write/mem_data : loader -> VRAM write port
interface sprite_vram_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_addr, mem_write, mem_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_addr, mem_write, mem_data
  );
endinterface

// File: rtl/sprite_vram_loader.sv
// rtl/sprite_vram_loader.sv - streams one raster-order sprite into VRAM during blanking
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   blank  : 1 while the display is not reading VRAM; writes only happen then
//   start  : one-cycle pulse, (re)starts a load at address 0
//   bus    : pixel stream in, registered VRAM write port out
//   busy   : load in progress
//   done   : one-cycle pulse on a correctly framed load
//   error  : sticky framing error, cleared by start
module sprite_vram_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int SPRITE_SIZE = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  blank,
  input  logic                  start,
  sprite_vram_loader_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(SPRITE_SIZE);
  localparam logic [CW-1:0] EDGE_MAX = CW'(SPRITE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         sprite_x, sprite_y;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  error_q;
  logic                  ready;
  logic                  restart;
  logic                  xfer;
  logic                  last_pixel;

  assign ready      = (state == LOAD) && blank;
  // start is honoured in IDLE and LOAD; in DONE it is dropped.
  assign restart    = start && (state != DONE);
  // A handshake coinciding with a restart is discarded.
  assign xfer       = bus.in_valid && ready && !start;
  assign last_pixel = (sprite_x == EDGE_MAX) && (sprite_y == EDGE_MAX);

  assign bus.in_ready  = ready;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.mem_write = write_q;
  assign busy          = (state == LOAD);
  assign done          = (state == DONE);
  assign error         = error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (start) begin
          state_next = LOAD;
        end else if (xfer) begin
          // Correct framing needs in_last exactly on the final pixel; any
          // mismatch ends the load without done.
          if (last_pixel && bus.in_last)      state_next = DONE;
          else if (last_pixel || bus.in_last) state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sprite_x <= '0;
      sprite_y <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      write_q <= 1'b0;
      if (restart) begin
        sprite_x <= '0;
        sprite_y <= '0;
        error_q  <= 1'b0;
      end else if (xfer) begin
        write_q <= 1'b1;
        addr_q  <= ADDR_WIDTH'(SPRITE_SIZE) * ADDR_WIDTH'(sprite_y) + ADDR_WIDTH'(sprite_x);
        data_q  <= bus.in_data;
        if (sprite_x == EDGE_MAX) begin
          sprite_x <= '0;
          sprite_y <= sprite_y + CW'(1);
        end else begin
          sprite_x <= sprite_x + CW'(1);
        end
        if (last_pixel != bus.in_last) error_q <= 1'b1;
      end
    end
  end

endmodule
